// File: rtl/mux_pkg.sv
// Shared constants, FSM state type and width helpers for the N-channel
// registered scan multiplexer.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [0:0] {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // Select width: max(1, clog2(n)).
  function automatic int sel_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Dwell counter width: clog2(dwell+1), never below one bit.
  function automatic int cnt_width(input int dwell);
    return ($clog2(dwell + 1) < 1) ? 1 : $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/mux_nxw_scan_if.sv
// Channel bank, select controls and the registered valid/ready output of
// the scan multiplexer, bundled as one bus.
interface mux_nxw_scan_if
  import mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int SW = sel_width(N)
);

  logic [N*W-1:0] I;
  logic [SW-1:0]  S;
  logic           mode;
  logic           en;
  logic           ready;
  logic [W-1:0]   Y;
  logic [SW-1:0]  Y_sel;
  logic           valid;

  modport master (
    output I, S, mode, en, ready,
    input  Y, Y_sel, valid
  );

  modport slave (
    input  I, S, mode, en, ready,
    output Y, Y_sel, valid
  );

endinterface

// File: rtl/mux_nxw_sel.sv
// Combinational N-to-1, W-bit channel selector; an index past the last
// channel yields zero instead of an X or an aliased channel.
module mux_nxw_sel
  import mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int SW = sel_width(N)
) (
  input  logic [N*W-1:0] data,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   y
);

  // Range-checked channel pick.
  always_comb begin
    if (int'(idx) < N) begin
      y = data[int'(idx)*W +: W];
    end else begin
      y = '0;
    end
  end

endmodule

// File: rtl/mux_nxw_scan.sv
// Registered N-channel, W-bit multiplexer with direct and round-robin scan
// modes, feeding a valid/ready consumer.
module mux_nxw_scan
  import mux_pkg::*;
#(
  parameter int  N     = 8,
  parameter int  W     = 1,
  parameter int  DWELL = 1,
  localparam int SW    = sel_width(N),
  localparam int CW    = cnt_width(DWELL)
) (
  input logic           clk,
  input logic           rst_n,
  mux_nxw_scan_if.slave bus
);

  state_t        state_r;
  state_t        state_s;
  logic [SW-1:0] ptr_r;
  logic [SW-1:0] ptr_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [SW-1:0] scan_ptr_s;
  logic [CW-1:0] scan_cnt_s;
  logic [SW-1:0] adv_ptr_s;
  logic [CW-1:0] adv_cnt_s;
  logic [SW-1:0] idx_s;
  logic [W-1:0]  sel_data_s;
  logic          load_s;
  logic [W-1:0]  y_r;
  logic [SW-1:0] y_sel_r;
  logic          valid_r;

  assign load_s = bus.en && (!valid_r || bus.ready);

  // Entering scan from direct starts from channel 0 with a fresh dwell.
  assign scan_ptr_s = (state_r == ST_SCAN) ? ptr_r : '0;
  assign scan_cnt_s = (state_r == ST_SCAN) ? cnt_r : '0;

  // Dwell/pointer advance; the pointer wraps at N-1, not at 2^SW-1.
  always_comb begin
    if (scan_cnt_s == CW'(DWELL - 1)) begin
      adv_cnt_s = '0;
      adv_ptr_s = (scan_ptr_s == SW'(N - 1)) ? '0 : scan_ptr_s + SW'(1);
    end else begin
      adv_cnt_s = scan_cnt_s + CW'(1);
      adv_ptr_s = scan_ptr_s;
    end
  end

  // Next state, scan pointer and sample index; mode only matters on a load.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    idx_s   = bus.S;
    if (load_s) begin
      case (state_r)
        ST_DIRECT: begin
          if (bus.mode == MODE_SCAN) begin
            state_s = ST_SCAN;
            idx_s   = scan_ptr_s;
            ptr_s   = adv_ptr_s;
            cnt_s   = adv_cnt_s;
          end else begin
            state_s = ST_DIRECT;
            idx_s   = bus.S;
          end
        end
        ST_SCAN: begin
          if (bus.mode == MODE_SCAN) begin
            state_s = ST_SCAN;
            idx_s   = scan_ptr_s;
            ptr_s   = adv_ptr_s;
            cnt_s   = adv_cnt_s;
          end else begin
            state_s = ST_DIRECT;
            idx_s   = bus.S;
            ptr_s   = '0;
            cnt_s   = '0;
          end
        end
        default: begin
          state_s = ST_DIRECT;
          idx_s   = bus.S;
          ptr_s   = '0;
          cnt_s   = '0;
        end
      endcase
    end else begin
      idx_s = bus.S;
    end
  end

  mux_nxw_sel #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_sel (
    .data (bus.I),
    .idx  (idx_s),
    .y    (sel_data_s)
  );

  // FSM, scan pointer and output register with handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_DIRECT;
      ptr_r   <= '0;
      cnt_r   <= '0;
      y_r     <= '0;
      y_sel_r <= '0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      if (load_s) begin
        y_r     <= sel_data_s;
        y_sel_r <= idx_s;
        valid_r <= 1'b1;
      end else if (valid_r && bus.ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign bus.Y     = y_r;
  assign bus.Y_sel = y_sel_r;
  assign bus.valid = valid_r;

endmodule
